icache: RTL and testbench
=========================

# icache

Direct-mapped instruction cache between the memory controller and the instruction fetcher. It answers same-cycle hits on the fetcher's PC. On a miss it fetches a whole line as a burst of 32-bit words from the memory controller, installs the line, and then serves the access as a hit. The cache is read-only: instruction memory is never written, so there is no write path, dirty state or flush.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of the line count (default 64 lines).
- OFFSET_WORDS_LOG, 2, log2 of words per line (default 4 words = 16 B).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- rdy  in  1  global ready; when low, all state freezes.
- icache_enable  in  1  fetcher requests the instruction at pc_to_icache.
- pc_to_icache  in  32  fetch address, word-aligned.
- icache_valid  out  1  icache_inst holds the instruction for pc_to_icache this cycle.
- icache_inst  out  32  hit word (don't-care when icache_valid=0).
- mem_req  out  1  line refill request, registered.
- mem_addr  out  32  line-aligned refill address, registered.
- mem_word_valid  in  1  the memory controller delivers one refill word this cycle.
- mem_word  in  32  refill word; words arrive in ascending address order.

## Operation
- Address split:
  - tag = pc[31 : INDEX_BITS+OFFSET_WORDS_LOG+2]
  - index = pc[INDEX_BITS+OFFSET_WORDS_LOG+1 : OFFSET_WORDS_LOG+2]
  - word = pc[OFFSET_WORDS_LOG+1 : 2]
  - pc[1:0] is ignored.
- Per-line storage: valid bit, tag, and 2^OFFSET_WORDS_LOG data words.
- FSM states:
  - IDLE:
    - hit = valid[index] and tag match.
    - icache_valid = icache_enable & hit (combinational). icache_inst = data[index][word].
    - On icache_enable & !hit: latch line address {tag, index, 0…} into mem_addr, set mem_req=1, clear the word counter, go to REFILL.
  - REFILL:
    - Each cycle with rdy & mem_word_valid: store mem_word into the staging buffer at position counter, then increment counter.
    - When the last word (counter = 2^OFFSET_WORDS_LOG−1) is accepted: write the staging buffer plus the last word into line[index], set valid, write the tag, drop mem_req, return to IDLE.
    - icache_valid=0 throughout REFILL.
- A PC change during REFILL (rollback, jalr redirect) does not abort the refill. The line completes and installs. The new PC is looked up in IDLE afterwards and may miss again.
- icache_enable deasserted during REFILL has no effect on the refill.
- mem_word_valid in IDLE is ignored.
- mem_req stays high for the whole refill. The memory controller owns word pacing.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, all valid bits=0, mem_req=0, mem_addr=0, counter=0.
  - icache_valid=0 while reset is asserted.
  - Data and tag arrays are not reset.
- Hit latency is 0 cycles: valid and instruction are combinational from pc_to_icache in the same cycle.
- Miss at cycle t (IDLE):
  - mem_req=1 and mem_addr valid from t+1.
  - If the last word is accepted at edge e, the line is installed and mem_req=0 after e.
  - The hit is available in the cycle after e.
  - Minimum miss penalty = 1 + 2^OFFSET_WORDS_LOG cycles, plus 1 cycle for the hit.
- rdy=0: no state, array, counter or output register changes. mem_word_valid is not counted. Combinational icache_valid still reflects IDLE hit logic.
- Counter width is OFFSET_WORDS_LOG bits. It wraps to 0 on the last word and needs no separate clear.
- Reset mid-refill: the refill is abandoned, mem_req drops asynchronously, and the partially filled line stays invalid.

## Structure
- Shared defines header: `True`/`False`, the address-split widths, and the state encodings IDLE/REFILL.
- Tag and valid arrays stay in `icache`.
- One natural sub-module: `icache_line_ram`. It is the data array, with an asynchronous read port and one synchronous line-wide write port, so it can be swapped for a block-RAM mapping later.

## Test plan
- Cold miss:
  1. After reset, hold enable=1, pc=0x0000_0010.
  2. Required: mem_req=1 and mem_addr=0x0000_0010 next cycle.
  3. Feed words 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
  4. Required: the cycle after the 4th word, icache_valid=1 and icache_inst=0xA0. With pc=0x1C, icache_inst=0xA3.
- Conflict eviction:
  1. Fill pc=0x0000_0000, then miss on pc=0x0000_0400 (same index, different tag).
  2. Required: refill at mem_addr=0x400.
  3. Required: a subsequent pc=0x0 misses again.
- Redirect mid-refill:
  1. Miss on 0x20.
  2. After 2 words, change pc to 0x100.
  3. Required: the refill of 0x20 completes, then a new request with mem_addr=0x100. A later 0x20 access hits without mem_req.
- rdy stall:
  1. During a refill, drop rdy for 3 cycles while pulsing mem_word_valid.
  2. Required: the counter is unchanged and no extra words are captured. The line data equals only the words delivered with rdy=1.
- Async reset mid-refill:
  1. Assert rst=0 between clock edges after 2 words.
  2. Required: mem_req=0 immediately.
  3. After release, the same pc misses and issues mem_addr again.
- Stray mem_word_valid in IDLE with a valid line resident: required no array change, and hits return the original data.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: flags,
// address-split widths and refill FSM states.
package icache_pkg;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned BYTE_OFF_BITS = 2;

    localparam int unsigned INDEX_BITS_DEF       = 6;
    localparam int unsigned OFFSET_WORDS_LOG_DEF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

endpackage

// File: rtl/icache_line_ram.sv
// Instruction data array: asynchronous word read, synchronous whole-line write.
// Kept separate so it can later be mapped onto block RAM.
module icache_line_ram
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS       = INDEX_BITS_DEF,
    parameter int unsigned OFFSET_WORDS_LOG = OFFSET_WORDS_LOG_DEF
) (
    input  logic                                          clk,
    input  logic [INDEX_BITS-1:0]                         rd_index,
    input  logic [OFFSET_WORDS_LOG-1:0]                   rd_word,
    output logic [WORD_W-1:0]                             rd_data,
    input  logic                                          wr_en,
    input  logic [INDEX_BITS-1:0]                         wr_index,
    input  logic [(2**OFFSET_WORDS_LOG)-1:0][WORD_W-1:0]  wr_line
);

    logic [(2**OFFSET_WORDS_LOG)-1:0][WORD_W-1:0] line_q [2**INDEX_BITS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            line_q[wr_index] <= wr_line;
        end
    end

    assign rd_data = line_q[rd_index][rd_word];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache: same-cycle hits, whole-line
// burst refill from the memory controller on a miss.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS       = INDEX_BITS_DEF,
    parameter int unsigned OFFSET_WORDS_LOG = OFFSET_WORDS_LOG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              icache_enable,
    input  logic [ADDR_W-1:0] pc_to_icache,
    output logic              icache_valid,
    output logic [WORD_W-1:0] icache_inst,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_word_valid,
    input  logic [WORD_W-1:0] mem_word
);

    localparam int unsigned OFF_LSB = OFFSET_WORDS_LOG + BYTE_OFF_BITS;
    localparam int unsigned TAG_LSB = INDEX_BITS + OFF_LSB;
    localparam int unsigned TAG_W   = ADDR_W - TAG_LSB;
    localparam int unsigned LINES   = 2**INDEX_BITS;
    localparam int unsigned WORDS   = 2**OFFSET_WORDS_LOG;
    localparam logic [OFFSET_WORDS_LOG-1:0] LAST_WORD = '1;

    typedef logic [WORDS-1:0][WORD_W-1:0] line_t;

    state_e                      state_q, state_d;
    logic [OFFSET_WORDS_LOG-1:0] counter_q, counter_d;
    logic                        mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [LINES-1:0]            valid_q, valid_d;
    line_t                       stage_q, stage_d;
    logic [TAG_W-1:0]            tag_q [LINES];
    logic                        install;

    logic [TAG_W-1:0]            pc_tag, refill_tag;
    logic [INDEX_BITS-1:0]       pc_index, refill_index;
    logic [OFFSET_WORDS_LOG-1:0] pc_word;
    logic                        hit;
    logic                        unused_pc_bits;

    assign pc_tag         = pc_to_icache[ADDR_W-1:TAG_LSB];
    assign pc_index       = pc_to_icache[TAG_LSB-1:OFF_LSB];
    assign pc_word        = pc_to_icache[OFF_LSB-1:BYTE_OFF_BITS];
    assign unused_pc_bits = ^pc_to_icache[BYTE_OFF_BITS-1:0];

    // Install target comes from the latched refill address, not the live PC,
    // so a redirect during refill still lands the line where it belongs.
    assign refill_tag   = mem_addr_q[ADDR_W-1:TAG_LSB];
    assign refill_index = mem_addr_q[TAG_LSB-1:OFF_LSB];

    assign hit = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy) begin
            case (state_q)
                IDLE:    if (icache_enable && !hit) state_d = REFILL;
                REFILL:  if (mem_word_valid && counter_q == LAST_WORD) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        icache_valid = False;
        if (state_q == IDLE && icache_enable && hit) begin
            icache_valid = True;
        end
    end

    always_comb begin
        counter_d  = counter_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        valid_d    = valid_q;
        stage_d    = stage_q;
        install    = False;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (icache_enable && !hit) begin
                        mem_req_d  = True;
                        mem_addr_d = {pc_to_icache[ADDR_W-1:OFF_LSB], {OFF_LSB{1'b0}}};
                        counter_d  = '0;
                    end
                end
                REFILL: begin
                    if (mem_word_valid) begin
                        stage_d[counter_q] = mem_word;
                        counter_d          = counter_q + 1'b1;
                        if (counter_q == LAST_WORD) begin
                            install               = True;
                            valid_d[refill_index] = True;
                            mem_req_d             = False;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_q  <= '0;
            mem_req_q  <= False;
            mem_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            counter_q  <= counter_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        stage_q <= stage_d;
        if (install) begin
            tag_q[refill_index] <= refill_tag;
        end
    end

    icache_line_ram #(
        .INDEX_BITS       (INDEX_BITS),
        .OFFSET_WORDS_LOG (OFFSET_WORDS_LOG)
    ) u_line_ram (
        .clk      (clk),
        .rd_index (pc_index),
        .rd_word  (pc_word),
        .rd_data  (icache_inst),
        .wr_en    (install),
        .wr_index (refill_index),
        .wr_line  (stage_d)
    );

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus queues expected hits and refill
// requests; a negedge monitor pops and compares whatever the cache presents.
module tb_icache;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        icache_enable;
    logic [31:0] pc_to_icache;
    logic        icache_valid;
    logic [31:0] icache_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_word_valid;
    logic [31:0] mem_word;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hit [$];
    logic [31:0] exp_req [$];
    logic        prev_req = 1'b0;

    icache #(
        .INDEX_BITS       (6),
        .OFFSET_WORDS_LOG (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .icache_enable  (icache_enable),
        .pc_to_icache   (pc_to_icache),
        .icache_valid   (icache_valid),
        .icache_inst    (icache_inst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_word_valid (mem_word_valid),
        .mem_word       (mem_word)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] e;
        if (icache_valid) begin
            if (exp_hit.size() == 0) begin
                check("unexpected_hit", {31'd0, icache_valid}, 32'd0);
            end else begin
                e = exp_hit.pop_front();
                check("hit_inst", icache_inst, e);
            end
        end
        if (mem_req && !prev_req) begin
            if (exp_req.size() == 0) begin
                check("unexpected_req", mem_addr, 32'hFFFF_FFFF);
            end else begin
                e = exp_req.pop_front();
                check("req_addr", mem_addr, e);
            end
        end
        prev_req = mem_req;
    end

    task automatic lookup(input logic [31:0] pc, input logic [31:0] inst);
        exp_hit.push_back(inst);
        icache_enable = 1'b1;
        pc_to_icache  = pc;
        @(posedge clk); #1;
        icache_enable = 1'b0;
    endtask

    task automatic feed(input logic [31:0] w);
        mem_word_valid = 1'b1;
        mem_word       = w;
        @(posedge clk); #1;
        mem_word_valid = 1'b0;
    endtask

    task automatic do_miss(input logic [31:0] pc, input logic [31:0] base);
        exp_req.push_back({pc[31:4], 4'h0});
        icache_enable = 1'b1;
        pc_to_icache  = pc;
        @(posedge clk); #1;
        check("req_latency", {31'd0, mem_req}, 32'd1);
        icache_enable = 1'b0;
        for (int i = 0; i < 4; i++) feed(base + i);
        check("req_drop", {31'd0, mem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; icache_enable = 1'b0; pc_to_icache = '0;
        mem_word_valid = 1'b0; mem_word = '0;
        repeat (2) @(posedge clk); #1;
        icache_enable = 1'b1;
        #1;
        check("rst_valid", {31'd0, icache_valid}, 32'd0);
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        icache_enable = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;

        // cold miss
        do_miss(32'h10, 32'hA0);
        lookup(32'h10, 32'hA0);
        lookup(32'h1C, 32'hA3);
        lookup(32'h14, 32'hA1);

        // conflict eviction on index 0
        do_miss(32'h0, 32'hD0);
        lookup(32'h0, 32'hD0);
        do_miss(32'h400, 32'hE0);
        lookup(32'h408, 32'hE2);
        do_miss(32'h0, 32'hF0);
        lookup(32'h4, 32'hF1);
        lookup(32'h10, 32'hA0);

        // redirect mid-refill
        exp_req.push_back(32'h20);
        icache_enable = 1'b1;
        pc_to_icache  = 32'h20;
        @(posedge clk); #1;
        feed(32'hB0);
        feed(32'hB1);
        pc_to_icache = 32'h100;
        exp_req.push_back(32'h100);
        feed(32'hB2);
        feed(32'hB3);
        check("redirect_gap", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        check("redirect_req", {31'd0, mem_req}, 32'd1);
        icache_enable = 1'b0;
        for (int i = 0; i < 4; i++) feed(32'hC0 + i);
        lookup(32'h20, 32'hB0);
        lookup(32'h2C, 32'hB3);
        lookup(32'h104, 32'hC1);

        // rdy stall during refill, stray words must not be captured
        exp_req.push_back(32'h30);
        icache_enable = 1'b1;
        pc_to_icache  = 32'h30;
        @(posedge clk); #1;
        icache_enable = 1'b0;
        feed(32'h50);
        feed(32'h51);
        rdy = 1'b0;
        mem_word = 32'hEEEE_EEEE;
        repeat (3) begin
            mem_word_valid = 1'b1;
            @(posedge clk); #1;
        end
        mem_word_valid = 1'b0;
        rdy = 1'b1;
        check("stall_req_held", {31'd0, mem_req}, 32'd1);
        feed(32'h52);
        feed(32'h53);
        for (int i = 0; i < 4; i++) lookup(32'h30 + 4 * i, 32'h50 + i);

        // rdy low in IDLE: hits still combinational, misses do not start a refill
        rdy = 1'b0;
        lookup(32'h18, 32'hA2);
        icache_enable = 1'b1;
        pc_to_icache  = 32'h200;
        repeat (2) @(posedge clk); #1;
        icache_enable = 1'b0;
        check("stall_no_req", {31'd0, mem_req}, 32'd0);
        rdy = 1'b1;

        // asynchronous reset mid-refill
        exp_req.push_back(32'h40);
        icache_enable = 1'b1;
        pc_to_icache  = 32'h40;
        @(posedge clk); #1;
        icache_enable = 1'b0;
        feed(32'h60);
        feed(32'h61);
        #2 rst = 1'b0;
        #1;
        check("areset_req", {31'd0, mem_req}, 32'd0);
        check("areset_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_miss(32'h40, 32'h70);
        lookup(32'h40, 32'h70);
        lookup(32'h44, 32'h71);
        do_miss(32'h10, 32'hA8);
        lookup(32'h1C, 32'hAB);

        // stray mem_word_valid while idle
        mem_word = 32'hDEAD_BEEF;
        repeat (3) begin
            mem_word_valid = 1'b1;
            @(posedge clk); #1;
        end
        mem_word_valid = 1'b0;
        lookup(32'h10, 32'hA8);
        lookup(32'h18, 32'hAA);

        repeat (3) @(posedge clk); #1;
        check("pending_hits", exp_hit.size(), 32'd0);
        check("pending_reqs", exp_req.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
